// File: rtl/gray_counter_ud.sv
// gray_counter_ud: parametrised up/down Gray counter with load, wrap pulse and optional saturate.
// Define GRAY_COUNTER_SAT_EN to add the sat port and saturating behaviour.
module gray_counter_ud #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef GRAY_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] bin_nxt;
  logic             wrap_nxt;
  logic             edge_hit;
  logic             hold_sat;
  assign edge_hit = up ? &bin : ~|bin;
`ifdef GRAY_COUNTER_SAT_EN
  assign hold_sat = sat & edge_hit;
`else
  assign hold_sat = 1'b0;
`endif
  always_comb begin
    bin_nxt  = load ? load_val
             : (en & ~hold_sat) ? (up ? bin + 1'b1 : bin - 1'b1)
             : bin;
    wrap_nxt = ~load & en & edge_hit & ~hold_sat;
  end
  // gray is derived from bin_nxt so both outputs describe the same count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin  <= RST_BIN;
      gray <= RST_BIN ^ (RST_BIN >> 1);
      wrap <= 1'b0;
    end else begin
      bin  <= bin_nxt;
      gray <= bin_nxt ^ (bin_nxt >> 1);
      wrap <= wrap_nxt;
    end
endmodule

// File: doc/gray_counter_ud.md
# gray_counter_ud

Parametrised up/down Gray-code counter: the successor to the fixed 8-bit up-only Gray counter. It adds configurable width, count enable, direction control, synchronous binary load, a registered wrap pulse and an optional saturate mode. It drives registered Gray outputs that are safe to hand to a synchroniser in another clock domain (e.g. FIFO pointers). A registered binary copy is also provided for local arithmetic.

## Interface
- WIDTH, 8, counter width in bits; legal range 2..32
- RESET_VAL, 0, binary count value loaded by reset; must be < 2^WIDTH
- clk  input  1  clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  synchronous load; overrides en
- load_val  input  WIDTH  binary value to load
- sat  input  1  1 = saturate at end of range, 0 = wrap (present only with GRAY_COUNTER_SAT_EN)
- gray  output  WIDTH  registered Gray-coded count
- bin  output  WIDTH  registered binary count
- wrap  output  1  registered one-cycle pulse: previous step wrapped around

## Operation
- Internal state is the binary register bin; the next value bin_nxt is computed each cycle.
- Priority per rising edge:
  - load: bin_nxt = load_val; wrap_nxt = 0
  - else en & up: bin_nxt = bin + 1, modulo 2^WIDTH
  - else en & ~up: bin_nxt = bin - 1, modulo 2^WIDTH
  - else: hold; wrap_nxt = 0
- Wrap: wrap_nxt = 1 when an enabled step crosses the range end, either max→0 going up or 0→max going down. Otherwise wrap_nxt = 0.
- Saturate (sat=1, macro enabled):
  - An enabled step at max going up, or at 0 going down, holds the value.
  - wrap_nxt = 0 in that case.
- gray is updated from the next value, not the current one: gray <= bin_nxt ^ (bin_nxt >> 1). gray and bin therefore always describe the same count in the same cycle, with no extra cycle of lag.
- Single-bit property:
  - Every en step, including a wrap, changes exactly one bit of gray.
  - A saturated hold or an idle cycle changes zero bits.
  - A load may change any number of bits.
- Direction may change on any cycle. The step uses the up value at that edge, and no dead cycle is inserted.
- All arithmetic is unsigned, WIDTH bits, with no carry out.

## Timing
- Reset values (asynchronous, immediate on rst rising):
  - bin = RESET_VAL
  - gray = RESET_VAL ^ (RESET_VAL >> 1)
  - wrap = 0
- Reset release: the first active edge with rst low may already count or load.
- Latency: an input sampled at edge N is visible on bin, gray and wrap after edge N, one cycle.
- wrap is high for exactly the one cycle after the wrapping edge. Consecutive wraps (WIDTH small, en held) produce one pulse each time.
- Simultaneous load and en: load wins and no step occurs.
- Reset asserted mid-count: outputs go to the reset values without waiting for a clock edge. An in-flight wrap pulse is cleared.
- Outputs are driven directly from flops, with no combinational path from inputs to outputs.

## Configuration
- GRAY_COUNTER_SAT_EN defined:
  - The sat port exists.
  - sat=1 selects saturating behaviour per Operation; sat=0 wraps.
- GRAY_COUNTER_SAT_EN undefined:
  - There is no sat port.
  - The counter always wraps.
  - No saturation compare logic is synthesised.

## Test plan
- Reset/up count (WIDTH=8, RESET_VAL=0):
  - Stimulus: rst pulse, then en=1, up=1 for 3 cycles.
  - Required: gray = 0x00, 0x01, 0x03, 0x02; bin = 0, 1, 2, 3; wrap = 0 throughout.
- Up wrap:
  - Stimulus: load_val=0xFE with load=1, then en=1, up=1 for 2 cycles.
  - Required: gray = 0x81, 0x80, 0x00; wrap = 1 only in the cycle gray=0x00.
  - Each step changes exactly one bit.
- Down wrap and direction change:
  - Stimulus: from 0, en=1, up=0 for 1 cycle, then up=1 for 1 cycle.
  - Required: bin = 0xFF then 0x00; gray = 0x80 then 0x00; wrap pulses after each step.
- Load priority:
  - Stimulus: load=1, en=1, load_val=0x2A.
  - Required: bin = 0x2A, gray = 0x3F, wrap = 0, with no step applied.
- Saturate (macro defined, sat=1, WIDTH=4):
  - Stimulus: load 0xF, en=1, up=1 for 3 cycles.
  - Required: bin stays 0xF, gray stays 0x8, wrap = 0.
  - Then up=0 from 0: bin stays 0.
- Async reset mid-count (RESET_VAL=5, WIDTH=4):
  - Stimulus: assert rst between clock edges while counting.
  - Required: bin = 5 and gray = 0x7 immediately, wrap = 0; counting resumes on the first edge after release.
